// File: rtl/sh_dreq_fifo_pkg.sv
// sh_dreq_fifo_pkg: shared defaults, DREQ state encoding and control-register bit positions.
package sh_dreq_fifo_pkg;
  localparam int FIFO_DEPTH  = 8;
  localparam int BLOCK_WORDS = 4;
  localparam int LEN_WIDTH   = 16;
  localparam int CTRL_68S    = 0;
  localparam int CTRL_FULL   = 1;
  localparam int CTRL_OVF    = 2;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} dreq_st_e;
  typedef logic [$clog2(FIFO_DEPTH):0] level_t;
endpackage

// File: rtl/sh_dreq_fifo_if.sv
// sh_dreq_fifo_if: host register port plus SH-side read/DMAC handshake.
interface sh_dreq_fifo_if import sh_dreq_fifo_pkg::*; #(parameter int LEN_W = LEN_WIDTH);
  logic             HOST_LEN_WR;
  logic [LEN_W-1:0] HOST_LEN_DI;
  logic             HOST_START;
  logic             HOST_STOP;
  logic             HOST_DATA_WR;
  logic [15:0]      HOST_DATA_DI;
  logic             HOST_FULL;
  logic             HOST_ACTIVE;
  logic [LEN_W-1:0] HOST_LEN_DO;
  logic             HOST_OVF;
  logic             SH_RD;
  logic [15:0]      SH_DO;
  logic             DACK;
  logic             DREQ_N;
  logic             SH_EMPTY;
  modport slave (
    input  HOST_LEN_WR, HOST_LEN_DI, HOST_START, HOST_STOP, HOST_DATA_WR, HOST_DATA_DI, SH_RD, DACK,
    output HOST_FULL, HOST_ACTIVE, HOST_LEN_DO, HOST_OVF, SH_DO, DREQ_N, SH_EMPTY
  );
  modport master (
    output HOST_LEN_WR, HOST_LEN_DI, HOST_START, HOST_STOP, HOST_DATA_WR, HOST_DATA_DI, SH_RD, DACK,
    input  HOST_FULL, HOST_ACTIVE, HOST_LEN_DO, HOST_OVF, SH_DO, DREQ_N, SH_EMPTY
  );
endinterface

// File: rtl/sh_dreq_fifo_mem.sv
// sh_dreq_fifo_mem: DEPTH x 16 show-ahead ring buffer; caller qualifies push/pop.
module sh_dreq_fifo_mem #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ce,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [15:0]   i_din,
  output logic [15:0]   o_dout,
  output logic [LW-1:0] o_level,
  output logic [LW-1:0] o_level_nxt,
  output logic          o_full,
  output logic          o_empty
);
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  assign o_dout      = r_mem[r_rptr];
  assign o_level     = r_level;
  assign o_level_nxt = r_level + LW'(i_push) - LW'(i_pop);
  assign o_full      = r_level == LW'(DEPTH);
  assign o_empty     = r_level == '0;
  // Storage is cleared on reset so the head word reads zero out of reset.
  always_ff @(posedge i_clk) begin
    if (i_ce) begin
      if (i_rst) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
        for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (i_push) begin
          r_mem[r_wptr] <= i_din;
          r_wptr        <= r_wptr + 1'b1;
        end
        if (i_pop) r_rptr <= r_rptr + 1'b1;
        r_level <= o_level_nxt;
      end
    end
  end
endmodule

// File: rtl/sh_dreq_fifo.sv
// sh_dreq_fifo: host-fed FIFO pacing an SH7604 DMAC channel via block-wise DREQ_N.
module sh_dreq_fifo import sh_dreq_fifo_pkg::*; #(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int BLOCK = BLOCK_WORDS,
  parameter int LEN_W = LEN_WIDTH,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input logic CLK,
  input logic RST,
  input logic CE,
  sh_dreq_fifo_if.slave bus
);
  logic [LW-1:0]    w_level, w_level_nxt, w_avail, r_bcnt, w_bcnt_nxt;
  logic             w_full, w_empty, w_push, w_pop, w_wr_ok, w_start_ok, w_stop;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic             r_active, r_ovf, r_dreq_n;
  dreq_st_e         r_st, w_st_nxt;
  assign w_stop     = bus.HOST_STOP;
  assign w_pop      = bus.SH_RD & ~w_empty;
  assign w_wr_ok    = bus.HOST_DATA_WR & r_active & (r_len != '0) & ~w_stop;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign w_push     = w_wr_ok & (~w_full | w_pop);
  assign w_start_ok = bus.HOST_START & (r_len != '0);
  assign w_avail    = w_level - LW'(w_pop);
  assign w_len_nxt  = (bus.HOST_LEN_WR & ~r_active) ? bus.HOST_LEN_DI : r_len - LEN_W'(w_push);
  sh_dreq_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_ce       (CE),
    .i_flush    (w_stop),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_din      (bus.HOST_DATA_DI),
    .o_dout     (bus.SH_DO),
    .o_level    (w_level),
    .o_level_nxt(w_level_nxt),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );
  // Only DACKed reads count against the block; CPU reads just drain the FIFO.
  always_comb begin
    w_st_nxt   = r_st;
    w_bcnt_nxt = r_bcnt;
    if (w_stop) w_st_nxt = ST_IDLE;
    else case (r_st)
      ST_IDLE: begin
        if (r_active && w_avail >= LW'(BLOCK)) begin
          w_st_nxt   = ST_REQ;
          w_bcnt_nxt = LW'(BLOCK);
        end else if (r_active && r_len == '0 && w_avail != '0) begin
          w_st_nxt   = ST_REQ;
          w_bcnt_nxt = w_avail;
        end
      end
      ST_REQ: begin
        if (bus.SH_RD && bus.DACK) begin
          w_bcnt_nxt = r_bcnt - 1'b1;
          w_st_nxt   = (r_bcnt == LW'(1)) ? ST_GAP : ST_REQ;
        end
      end
      default: w_st_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (CE) begin
      if (RST) begin
        r_len    <= '0;
        r_active <= 1'b0;
        r_ovf    <= 1'b0;
        r_st     <= ST_IDLE;
        r_bcnt   <= '0;
        r_dreq_n <= 1'b1;
      end else begin
        r_len    <= w_len_nxt;
        r_ovf    <= w_stop ? r_ovf : w_start_ok ? 1'b0 : r_ovf | (w_wr_ok & w_full & ~w_pop);
        r_active <= w_stop ? 1'b0 : w_start_ok ? 1'b1 :
                    (w_len_nxt == '0 && w_level_nxt == '0) ? 1'b0 : r_active;
        r_st     <= w_st_nxt;
        r_bcnt   <= w_bcnt_nxt;
        r_dreq_n <= w_st_nxt != ST_REQ;
      end
    end
  end
  assign bus.HOST_FULL   = w_full;
  assign bus.SH_EMPTY    = w_empty;
  assign bus.HOST_ACTIVE = r_active;
  assign bus.HOST_LEN_DO = r_len;
  assign bus.HOST_OVF    = r_ovf;
  assign bus.DREQ_N      = r_dreq_n;
endmodule

// File: tb/tb_sh_dreq_fifo.sv
// tb_sh_dreq_fifo: directed plan plus random traffic against a queue-based reference model.
module tb_sh_dreq_fifo;
  localparam int DEPTH = 8;
  localparam int BLOCK = 4;
  logic clk = 1'b0;
  logic rst, ce;
  always #5 clk = ~clk;
  sh_dreq_fifo_if bus();
  sh_dreq_fifo dut (.CLK(clk), .RST(rst), .CE(ce), .bus(bus));
  logic [15:0] q[$];
  logic [15:0] obs[$];
  int  m_len, m_bleft;
  bit  m_act, m_ovf, m_gap, m_ok;
  int  errs = 0, checks = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_step();
    int sz, ol;
    bit pop, wrok, push, st_ok;
    if (!ce) return;
    if (rst) begin
      q.delete(); m_len = 0; m_act = 0; m_ovf = 0; m_bleft = 0; m_gap = 0; m_ok = 1;
      return;
    end
    sz = q.size();
    ol = m_len;
    pop = bus.SH_RD && sz > 0;
    if (bus.HOST_LEN_WR && !m_act) m_len = int'(bus.HOST_LEN_DI);
    if (bus.HOST_STOP) begin
      q.delete(); m_act = 0; m_bleft = 0; m_gap = 0;
      return;
    end
    wrok  = bus.HOST_DATA_WR && m_act && ol != 0;
    push  = wrok && (sz < DEPTH || pop);
    st_ok = bus.HOST_START && ol != 0;
    if (m_gap) m_gap = 0;
    else if (m_bleft > 0) begin
      if (bus.SH_RD && bus.DACK) begin
        m_bleft--;
        m_gap = (m_bleft == 0);
      end
    end else if (m_act && sz - int'(pop) >= BLOCK) m_bleft = BLOCK;
    else if (m_act && ol == 0 && sz - int'(pop) > 0) m_bleft = sz - int'(pop);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(bus.HOST_DATA_DI);
      m_len = ol - 1;
    end
    if (st_ok) m_ovf = 0;
    else if (wrok && !push) m_ovf = 1;
    if (st_ok) m_act = 1;
    else if (m_len == 0 && q.size() == 0) m_act = 0;
  endtask
  task automatic cyc();
    if (m_ok && q.size() > 0) chk("SH_DO", bus.SH_DO, q[0]);
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (m_ok) begin
      chk("DREQ_N", bus.DREQ_N, m_bleft == 0);
      chk("HOST_FULL", bus.HOST_FULL, q.size() == DEPTH);
      chk("SH_EMPTY", bus.SH_EMPTY, q.size() == 0);
      chk("HOST_ACTIVE", bus.HOST_ACTIVE, m_act);
      chk("HOST_LEN_DO", bus.HOST_LEN_DO, m_len);
      chk("HOST_OVF", bus.HOST_OVF, m_ovf);
    end
  endtask
  task automatic clr();
    ce = 1; rst = 0;
    bus.HOST_LEN_WR = 0; bus.HOST_LEN_DI = '0; bus.HOST_START = 0; bus.HOST_STOP = 0;
    bus.HOST_DATA_WR = 0; bus.HOST_DATA_DI = '0; bus.SH_RD = 0; bus.DACK = 0;
  endtask
  task automatic idle(input int n);
    clr();
    repeat (n) cyc();
  endtask
  task automatic setlen(input int n);
    clr(); bus.HOST_LEN_WR = 1; bus.HOST_LEN_DI = 16'(n); cyc(); clr();
  endtask
  task automatic start();
    clr(); bus.HOST_START = 1; cyc(); clr();
  endtask
  task automatic stop();
    clr(); bus.HOST_STOP = 1; cyc(); clr();
  endtask
  task automatic push(input logic [15:0] d);
    clr(); bus.HOST_DATA_WR = 1; bus.HOST_DATA_DI = d; cyc(); clr();
  endtask
  task automatic rd(input bit dack);
    clr(); bus.SH_RD = 1; bus.DACK = dack; obs.push_back(bus.SH_DO); cyc(); clr();
  endtask
  task automatic pushpop(input logic [15:0] d);
    clr(); bus.HOST_DATA_WR = 1; bus.HOST_DATA_DI = d; bus.SH_RD = 1;
    obs.push_back(bus.SH_DO); cyc(); clr();
  endtask
  logic [15:0] blk [4];
  initial begin
    blk = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    m_ok = 0;
    clr(); rst = 1; cyc(); clr();
    chk("rst_dreq", bus.DREQ_N, 1);
    chk("rst_full", bus.HOST_FULL, 0);
    chk("rst_empty", bus.SH_EMPTY, 1);
    chk("rst_sh_do", bus.SH_DO, 0);
    chk("rst_active", bus.HOST_ACTIVE, 0);
    chk("rst_len", bus.HOST_LEN_DO, 0);
    chk("rst_ovf", bus.HOST_OVF, 0);
    // basic block of four
    setlen(4); start();
    for (int i = 0; i < 3; i++) push(blk[i]);
    push(blk[3]);
    chk("blk_dreq_wait", bus.DREQ_N, 1);
    idle(1);
    chk("blk_dreq_asrt", bus.DREQ_N, 0);
    obs.delete();
    for (int i = 0; i < 4; i++) begin
      rd(1);
      if (i == 2) chk("blk_dreq_held", bus.DREQ_N, 0);
    end
    chk("blk_gap", bus.DREQ_N, 1);
    chk("blk_active", bus.HOST_ACTIVE, 0);
    for (int i = 0; i < 4; i++) chk("blk_data", obs[i], blk[i]);
    idle(1);
    chk("blk_post_gap", bus.DREQ_N, 1);
    // tail flush
    setlen(6); start();
    for (int i = 0; i < 6; i++) push(16'(16'h0100 + i));
    obs.delete();
    repeat (4) rd(1);
    chk("tail_gap", bus.DREQ_N, 1);
    idle(2);
    chk("tail_req", bus.DREQ_N, 0);
    rd(1);
    chk("tail_mid", bus.DREQ_N, 0);
    rd(1);
    chk("tail_end_dreq", bus.DREQ_N, 1);
    chk("tail_empty", bus.SH_EMPTY, 1);
    chk("tail_active", bus.HOST_ACTIVE, 0);
    chk("tail_last", obs[5], 16'h0105);
    // full and overflow
    setlen(12); start();
    for (int i = 1; i <= 9; i++) begin
      push(16'(i));
      if (i == 7) chk("ovf_not_full", bus.HOST_FULL, 0);
      if (i == 8) chk("ovf_full", bus.HOST_FULL, 1);
    end
    chk("ovf_flag", bus.HOST_OVF, 1);
    chk("ovf_len", bus.HOST_LEN_DO, 4);
    stop();
    // simultaneous push/pop at level 8 across pointer wrap
    setlen(16); start();
    chk("wrap_ovf_clr", bus.HOST_OVF, 0);
    for (int i = 1; i <= 8; i++) push(16'(i));
    obs.delete();
    for (int i = 9; i <= 16; i++) pushpop(16'(i));
    chk("wrap_full", bus.HOST_FULL, 1);
    repeat (8) rd(0);
    for (int i = 0; i < 16; i++) chk("wrap_order", obs[i], 16'(i + 1));
    chk("wrap_active", bus.HOST_ACTIVE, 0);
    // abort while requesting
    stop(); setlen(8); start();
    for (int i = 0; i < 4; i++) push(16'(16'hA000 + i));
    idle(1);
    chk("abort_req", bus.DREQ_N, 0);
    rd(1);
    stop();
    chk("abort_dreq", bus.DREQ_N, 1);
    chk("abort_empty", bus.SH_EMPTY, 1);
    chk("abort_active", bus.HOST_ACTIVE, 0);
    chk("abort_len", bus.HOST_LEN_DO, 4);
    // guards
    setlen(0); start();
    chk("start_len0", bus.HOST_ACTIVE, 0);
    setlen(8); start(); setlen(3);
    chk("lenwr_ignored", bus.HOST_LEN_DO, 8);
    for (int i = 0; i < 8; i++) push(16'(16'hB000 + i));
    rd(0); rd(0);
    chk("cpu_rd_dreq", bus.DREQ_N, 0);
    repeat (3) rd(1);
    chk("dack3_dreq", bus.DREQ_N, 0);
    rd(1);
    chk("dack4_dreq", bus.DREQ_N, 1);
    stop();
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      clr();
      ce               = ($urandom_range(0, 9) != 0);
      rst              = ($urandom_range(0, 499) == 0);
      bus.HOST_STOP    = ($urandom_range(0, 99) == 0);
      bus.HOST_START   = ($urandom_range(0, 19) == 0);
      bus.HOST_LEN_WR  = ($urandom_range(0, 29) == 0);
      bus.HOST_LEN_DI  = 16'($urandom_range(0, 20));
      bus.HOST_DATA_WR = ($urandom_range(0, 1) == 0);
      bus.HOST_DATA_DI = 16'($urandom);
      bus.SH_RD        = ($urandom_range(0, 4) < 2);
      bus.DACK         = ($urandom_range(0, 3) != 0);
      cyc();
    end
    clr();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
